seg7_scan_driver: RTL and testbench

// - Parametrised multiplexed seven-segment driver for the board display: N_DIGITS digits, VAL_W-bit binary input.
// - Sequential binary-to-BCD conversion, leading-zero blanking, overflow dashes, and PC/INP/blank text modes.
// - Sits between the processor status outputs (value, mode, busy) and the board segment/anode pins.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the seven-segment scan driver: modes, glyphs, converter states.
package seg7_pkg;

  localparam logic [1:0] MODE_DEC   = 2'd0;
  localparam logic [1:0] MODE_PC    = 2'd1;
  localparam logic [1:0] MODE_INP   = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Decimal nibble to glyph; codes above 9 are unreachable and shown blank
  function automatic logic [6:0] bcd_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned VAL_W = 8,
  parameter int unsigned N_BCD = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [VAL_W-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_BCD-1:0]   bcd
);

  localparam int unsigned ACC_W = 4 * N_BCD;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  conv_state_e        state_q, state_d;
  logic [VAL_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   adj_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state: latch on start, add-3/shift for VAL_W cycles, present result for one cycle
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    adj_c   = acc_q;
    for (int unsigned i = 0; i < N_BCD; i++) begin
      if (adj_c[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, sr_d} = {adj_c[ACC_W-2:0], sr_q, 1'b0};
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Converter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: prescaled digit scan, BCD conversion, text modes.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned VAL_W    = 8,
  parameter int unsigned DIV      = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VAL_W-1:0]    val,
  input  logic [1:0]          mode,
  input  logic                busy,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          busy_led
);

  localparam int unsigned DIG_W = $clog2(N_DIGITS);
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned ACC_W = 4 * (N_DIGITS + 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          busy_led_q, busy_led_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic                ovf_q, ovf_d;

  logic                conv_busy, conv_done;
  logic [ACC_W-1:0]    conv_bcd;
  logic                start_c, tick_c, all_zero_c;
  logic [N_DIGITS-1:0] zero_from_c;
  logic [3:0]          nib_c;
  logic [6:0]          glyph_c;

  // A new value is only accepted while the converter is idle, so the latest val always wins
  assign start_c = (val != val_q) && !conv_busy;
  assign tick_c  = (presc_q == PRE_W'(DIV - 1));

  bin2bcd_seq #(
    .VAL_W (VAL_W),
    .N_BCD (N_DIGITS + 1)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_c),
    .bin   (val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Glyph for the digit currently being scanned
  always_comb begin
    all_zero_c  = 1'b1;
    zero_from_c = '0;
    nib_c       = '0;
    glyph_c     = SEG_BLANK;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero_c     = all_zero_c & (bcd_q[4*i +: 4] == 4'd0);
      zero_from_c[i] = all_zero_c;
    end
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (DIG_W'(i) == digit_q) begin
        nib_c = bcd_q[4*i +: 4];
      end
    end
    case (mode)
      MODE_DEC: begin
        if (ovf_q)                                          glyph_c = SEG_DASH;
        else if ((digit_q != '0) && zero_from_c[digit_q])   glyph_c = SEG_BLANK;
        else                                                glyph_c = bcd_glyph(nib_c);
      end
      MODE_PC: begin
        if (digit_q == DIG_W'(N_DIGITS - 1))      glyph_c = SEG_P;
        else if (digit_q == DIG_W'(N_DIGITS - 2)) glyph_c = SEG_C;
        else if (ovf_q)                           glyph_c = SEG_DASH;
        else                                      glyph_c = bcd_glyph(nib_c);
      end
      MODE_INP: begin
        if (digit_q == DIG_W'(2))      glyph_c = SEG_I;
        else if (digit_q == DIG_W'(1)) glyph_c = SEG_N;
        else if (digit_q == '0)        glyph_c = SEG_P;
        else                           glyph_c = SEG_BLANK;
      end
      default: glyph_c = SEG_BLANK;
    endcase
  end

  // Prescaler, scan advance, output loads and result commit
  always_comb begin
    presc_d    = presc_q;
    digit_d    = digit_q;
    seg_d      = seg_q;
    an_d       = an_q;
    bcd_d      = bcd_q;
    val_d      = val_q;
    ovf_d      = ovf_q;
    busy_led_d = {8{busy}};
    if (tick_c) begin
      presc_d = '0;
      an_d    = ~(N_DIGITS'(1) << digit_q);
      seg_d   = glyph_c;
      digit_d = (digit_q == DIG_W'(N_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
    if (start_c) begin
      val_d = val;
    end
    if (conv_done) begin
      bcd_d = conv_bcd[BCD_W-1:0];
      ovf_d = (conv_bcd[ACC_W-1 -: 4] != 4'd0);
    end
  end

  // Output and display-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      digit_q    <= '0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
      busy_led_q <= '0;
      bcd_q      <= '0;
      val_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      busy_led_q <= busy_led_d;
      bcd_q      <= bcd_d;
      val_q      <= val_d;
      ovf_q      <= ovf_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign busy_led = busy_led_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: randomized 8-bit instance plus a directed 16-bit instance.
module tb_seg7_scan_driver;

  localparam int N_A   = 4;
  localparam int VW_A  = 8;
  localparam int DIV_A = 4;
  localparam int N_B   = 4;
  localparam int VW_B  = 16;
  localparam int DIV_B = 32;
  localparam int ROUND_A = N_A * DIV_A;
  localparam int SETTLE  = 2 * (VW_A + 2) + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [VW_A-1:0] val_a;
  logic [1:0]      mode_a;
  logic            busy_a;
  logic [6:0]      seg_a;
  logic [N_A-1:0]  an_a;
  logic [7:0]      bl_a;

  logic [VW_B-1:0] val_b;
  logic [1:0]      mode_b;
  logic            busy_b;
  logic [6:0]      seg_b;
  logic [N_B-1:0]  an_b;
  logic [7:0]      bl_b;

  seg7_scan_driver #(.N_DIGITS(N_A), .VAL_W(VW_A), .DIV(DIV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .val(val_a), .mode(mode_a), .busy(busy_a),
    .seg(seg_a), .an(an_a), .busy_led(bl_a));

  seg7_scan_driver #(.N_DIGITS(N_B), .VAL_W(VW_B), .DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .val(val_b), .mode(mode_b), .busy(busy_b),
    .seg(seg_b), .an(an_b), .busy_led(bl_b));

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    bit         chk_seg;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         last_chg = 0;
  bit         busy_smp = 1'b0;
  logic [3:0] prev_an = 4'hF;

  function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference glyph table
  function automatic logic [6:0] ref_digit(input int dg);
    case (dg)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // What digit d (0 = rightmost) should show for value v in mode m, from decimal arithmetic
  function automatic logic [6:0] ref_seg(input int v, input int m, input int d, input int ndig);
    int p;
    int lim;
    p = 1;
    lim = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    for (int k = 0; k < ndig; k++) lim = lim * 10;
    if (m == 3) return 7'b1111111;
    if (m == 2) begin
      if (d == 2) return 7'b1111001;
      if (d == 1) return 7'b0101011;
      if (d == 0) return 7'b0001100;
      return 7'b1111111;
    end
    if (m == 1) begin
      if (d == ndig - 1) return 7'b0001100;
      if (d == ndig - 2) return 7'b1000110;
      if (v >= lim) return 7'b0111111;
      return ref_digit((v / p) % 10);
    end
    if (v >= lim) return 7'b0111111;
    if (d > 0 && v < p) return 7'b1111111;
    return ref_digit((v / p) % 10);
  endfunction

  // Model: every DIV_A clocks a new digit slot is expected; push what it must show
  always @(posedge clk or negedge rst_n) begin : model_a
    exp_t e;
    int   d;
    if (!rst_n) begin
      cyc      = 0;
      busy_smp = 1'b0;
      sb_q.delete();
    end else begin
      cyc++;
      busy_smp = busy_a;
      if (cyc % DIV_A == 0) begin
        d         = (cyc / DIV_A - 1) % N_A;
        e.an      = ~(4'b0001 << d);
        e.seg     = ref_seg(int'(val_a), int'(mode_a), d, N_A);
        e.chk_seg = (cyc - last_chg) > SETTLE;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: compare busy_led every cycle, and each new digit slot against the scoreboard
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_n) begin
      prev_an = 4'hF;
    end else begin
      check("busy_led_a", 32'(bl_a), busy_smp ? 32'hFF : 32'h0);
      if (sb_q.size() > 1) begin
        n_chk++;
        $display("FAIL scan_a: %0d slots pending, an did not advance at %0t", sb_q.size(), $time);
        sb_q.delete();
      end
      if (an_a !== prev_an) begin
        prev_an = an_a;
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL scan_a: an changed to %b with no slot due at %0t", an_a, $time);
        end else begin
          e = sb_q.pop_front();
          check("an_a", 32'(an_a), 32'(e.an));
          if (e.chk_seg) check("seg_a", 32'(seg_a), 32'(e.seg));
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) busy_a = ~busy_a;
    end
  endtask

  task automatic rand_step();
    mode_a = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       val_a = '0;
      1:       val_a = VW_A'($urandom_range(1, 9));
      2:       val_a = VW_A'($urandom_range(10, 99));
      default: val_a = VW_A'($urandom_range(0, 255));
    endcase
    last_chg = cyc;
    hold($urandom_range(SETTLE + 2 * ROUND_A, SETTLE + 4 * ROUND_A));
    if ($urandom_range(0, 1) == 1) begin
      mode_a = 2'($urandom_range(0, 3));
      hold(2 * ROUND_A);
    end
  endtask

  // Collect one full scan round of the 16-bit instance and compare every digit
  task automatic observe_b(input int v, input int m, input string tag);
    logic [3:0] prev;
    int         got;
    int         idx;
    prev = an_b;
    got  = 0;
    for (int c = 0; c < 6 * N_B * DIV_B && got < N_B; c++) begin
      @(negedge clk);
      if (an_b !== prev) begin
        prev = an_b;
        idx  = -1;
        for (int i = 0; i < N_B; i++) if (an_b == ~(4'b0001 << i)) idx = i;
        if (idx < 0) begin
          n_chk++;
          $display("FAIL %s: an=%b not one-hot-low", tag, an_b);
        end else begin
          check(tag, 32'(seg_b), 32'(ref_seg(v, m, idx, N_B)));
        end
        got++;
      end
    end
    if (got < N_B) begin
      n_chk++;
      $display("FAIL %s: only %0d digit slots seen", tag, got);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    val_a  = '0;
    mode_a = 2'd0;
    busy_a = 1'b0;
    val_b  = '0;
    mode_b = 2'd0;
    busy_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an_a",  32'(an_a),  32'hF);
    check("rst_seg_a", 32'(seg_a), 32'h7F);
    check("rst_bl_a",  32'(bl_a),  32'h0);
    check("rst_an_b",  32'(an_b),  32'hF);
    check("rst_bl_b",  32'(bl_b),  32'h0);
    rst_n    = 1'b1;
    last_chg = 0;

    // val=0 in DEC: single '0' on the rightmost digit
    hold(SETTLE + 2 * ROUND_A);

    // Conversion latency: result committed exactly on the 10th clock after the change
    busy_a   = 1'b0;
    val_a    = 8'd237;
    last_chg = cyc;
    repeat (9) @(negedge clk);
    check("bcd_lat9",  32'(dut_a.bcd_q), 32'h0000);
    @(negedge clk);
    check("bcd_lat10", 32'(dut_a.bcd_q), 32'h0237);
    hold(SETTLE + 2 * ROUND_A);

    // Directed modes
    mode_a = 2'd1; val_a = 8'd5; last_chg = cyc; busy_a = 1'b1;
    hold(SETTLE + 2 * ROUND_A);
    mode_a = 2'd2;
    hold(2 * ROUND_A);
    mode_a = 2'd3;
    hold(2 * ROUND_A);

    for (int it = 0; it < 30; it++) rand_step();

    // Asynchronous reset in the middle of a slot
    @(posedge clk);
    busy_a = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_an_a",  32'(an_a),  32'hF);
    check("mid_rst_seg_a", 32'(seg_a), 32'h7F);
    check("mid_rst_bl_a",  32'(bl_a),  32'h0);
    check("mid_rst_an_b",  32'(an_b),  32'hF);
    check("mid_rst_seg_b", 32'(seg_b), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_chg = 0;
    hold(SETTLE + 2 * ROUND_A);

    for (int it = 0; it < 8; it++) rand_step();

    // 16-bit instance: overflow, PC overflow, change applied during a conversion
    val_b = 16'd12345;
    repeat (100) @(negedge clk);
    observe_b(12345, 0, "ovf_dec_b");
    mode_b = 2'd1;
    repeat (10) @(negedge clk);
    observe_b(12345, 1, "ovf_pc_b");
    mode_b = 2'd0;
    val_b  = 16'd9999;
    repeat (5) @(negedge clk);
    val_b = 16'd1234;
    repeat (100) @(negedge clk);
    observe_b(1234, 0, "mid_shift_b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
